// File: rtl/mem_channel_arbiter.sv
`default_nettype none
// mem_channel_arbiter: round-robin two-lane arbiter onto one fixed-latency single-port memory.
// Optional build macro MEM_ARB_PROTOCOL_CHECK_EN enables the sticky requester-protocol flag on err.
module mem_channel_arbiter #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8,
  parameter int SIZE_W = 4,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            req_oe,
  input  logic [1:0]            req_we,
  input  logic [2*ADDR_W-1:0]   req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  input  logic [2*SIZE_W-1:0]   req_size,
  output logic [2*DATA_W-1:0]   req_rdata,
  output logic [1:0]            req_rdy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W-1:0]     mem_mask,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err
);

  localparam int MAX_LAT = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_ACCESS   = 2'd1,
    S_WAIT     = 2'd2,
    S_COOLDOWN = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;
  logic                win_q, win_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [1:0]          lane_req;
  logic                grant;
  logic [ADDR_W-1:0]   lane_addr;
  logic [DATA_W-1:0]   lane_wdata;
  logic [SIZE_W-1:0]   lane_size;
  logic [DATA_W-1:0]   lane_mask;
  logic                rdy;
  logic [DATA_W-1:0]   rd_lane;

  // Bit i is enabled when i < size; sizes at or beyond DATA_W saturate to all ones.
  function automatic logic [DATA_W-1:0] size_mask(input logic [SIZE_W-1:0] size);
    logic [DATA_W-1:0] m;
    for (int i = 0; i < DATA_W; i++) begin
      m[i] = (int'(size) > i);
    end
    return m;
  endfunction

  assign lane_req   = req_oe | req_we;
  assign grant      = (lane_req == 2'b11) ? ptr_q : lane_req[1];
  assign lane_addr  = grant ? req_addr[ADDR_W +: ADDR_W]   : req_addr[0 +: ADDR_W];
  assign lane_wdata = grant ? req_wdata[DATA_W +: DATA_W]  : req_wdata[0 +: DATA_W];
  assign lane_size  = grant ? req_size[SIZE_W +: SIZE_W]   : req_size[0 +: SIZE_W];
  assign lane_mask  = size_mask(lane_size);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= 1'b0;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (|lane_req) begin
          // A lane strobing both oe and we is served as a read.
          win_d   = grant;
          we_d    = ~req_oe[grant];
          addr_d  = lane_addr;
          wdata_d = lane_wdata & lane_mask;
          mask_d  = lane_mask;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        cnt_d   = we_q ? CNT_W'(WR_LAT) : CNT_W'(RD_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_COOLDOWN;
        end
      end
      S_COOLDOWN: begin
        ptr_d   = ~win_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rdy       = (state_q == S_WAIT) && (cnt_q == CNT_W'(1));
  assign req_rdy   = {rdy & win_q, rdy & ~win_q};
  assign rd_lane   = (rdy && !we_q) ? (mem_rdata & mask_q) : '0;
  assign req_rdata = win_q ? {rd_lane, {DATA_W{1'b0}}} : {{DATA_W{1'b0}}, rd_lane};

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q  : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign mem_mask  = mem_en ? mask_q  : '0;

`ifdef MEM_ARB_PROTOCOL_CHECK_EN
  logic              err_q, err_d;
  logic              in_flight;
  logic [ADDR_W-1:0] win_addr;

  // The granted lane must keep its request and address until its completion pulse.
  always_comb begin
    in_flight = (state_q == S_ACCESS) || (state_q == S_WAIT);
    win_addr  = win_q ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
    err_d     = err_q | (|(req_oe & req_we)) |
                (in_flight & (~lane_req[win_q] | (win_addr != addr_q)));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_channel_arbiter.sv
`default_nettype none
// tb_mem_channel_arbiter: directed self-checking bench for mem_channel_arbiter (default parameters).
module tb_mem_channel_arbiter;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 8;
  localparam int SIZE_W = 4;

`ifdef MEM_ARB_PROTOCOL_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          req_oe, req_we;
  logic [2*ADDR_W-1:0] req_addr;
  logic [2*DATA_W-1:0] req_wdata;
  logic [2*SIZE_W-1:0] req_size;
  logic [2*DATA_W-1:0] req_rdata;
  logic [1:0]          req_rdy;
  logic                mem_en, mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata, mem_mask, mem_rdata;
  logic                err;

  int n_checks = 0;
  int n_pass   = 0;

  mem_channel_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SIZE_W(SIZE_W), .RD_LAT(2), .WR_LAT(1)
  ) dut (
    .clock(clock), .reset(reset),
    .req_oe(req_oe), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size),
    .req_rdata(req_rdata), .req_rdy(req_rdy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_rdata(mem_rdata),
    .err(err)
  );

  always #5 clock = ~clock;

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    req_oe = '0; req_we = '0; req_addr = '0; req_wdata = '0; req_size = '0; mem_rdata = '0;
  endtask

  task automatic set_lane(input int l, input logic oe, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [SIZE_W-1:0] s);
    req_oe[l] = oe;
    req_we[l] = we;
    req_addr[l*ADDR_W +: ADDR_W]  = a;
    req_wdata[l*DATA_W +: DATA_W] = d;
    req_size[l*SIZE_W +: SIZE_W]  = s;
  endtask

  task automatic test_reset();
    logic [50:0] outs;
    reset = 1'b0;
    clear_inputs();
    cyc(); cyc(); #1;
    outs = {req_rdata, req_rdy, mem_en, mem_we, mem_addr, mem_wdata, mem_mask, err};
    n_checks++;
    if (outs !== '0) $display("FAIL reset_outputs: got %0h want 0", outs); else n_pass++;
    cyc(); reset = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic [50:0] outs;
    logic        quiet;
    cyc(); set_lane(0, 1'b1, 1'b0, 9'h033, 8'h00, 4'd8);           // cycle 0
    cyc(); #1;                                                       // cycle 1
    n_checks++;
    if (mem_en !== 1'b1) $display("FAIL abort_mem_en: got %b want 1", mem_en); else n_pass++;
    cyc(); #1;                                                       // cycle 2 (WAIT)
    reset = 1'b0; #1;
    outs = {req_rdata, req_rdy, mem_en, mem_we, mem_addr, mem_wdata, mem_mask, err};
    n_checks++;
    if (outs !== '0) $display("FAIL abort_outputs_zero: got %0h want 0", outs); else n_pass++;
    clear_inputs();
    cyc(); reset = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(); #1;
      if (req_rdy !== 2'b00 || mem_en !== 1'b0) quiet = 1'b0;
    end
    n_checks++;
    if (quiet !== 1'b1) $display("FAIL abort_no_activity: got %b want 1", quiet); else n_pass++;
    cyc(); set_lane(1, 1'b1, 1'b0, 9'h044, 8'h00, 4'd8);           // cycle 0
    cyc(); #1;                                                       // cycle 1
    n_checks++;
    if ({mem_en, mem_addr} !== {1'b1, 9'h044})
      $display("FAIL abort_new_req: got en=%b addr=%0h want en=1 addr=44", mem_en, mem_addr);
    else n_pass++;
    cyc(); cyc(); mem_rdata = 8'h11; #1;                             // cycle 3
    n_checks++;
    if ({req_rdy, req_rdata} !== {2'b10, 16'h1100})
      $display("FAIL abort_new_cpl: got rdy=%b data=%0h want rdy=10 data=1100", req_rdy, req_rdata);
    else n_pass++;
    cyc(); clear_inputs();                                           // cooldown
  endtask

  task automatic test_single_read();
    cyc(); set_lane(0, 1'b1, 1'b0, 9'h005, 8'h3C, 4'd8); #1;        // cycle 0
    n_checks++;
    if (mem_en !== 1'b0) $display("FAIL read_c0_en: got %b want 0", mem_en); else n_pass++;
    cyc(); #1;                                                       // cycle 1
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_mask} !== {1'b1, 1'b0, 9'h005, 8'hFF})
      $display("FAIL read_access: got en=%b we=%b addr=%0h mask=%0h want 1 0 5 ff",
               mem_en, mem_we, mem_addr, mem_mask);
    else n_pass++;
    cyc(); #1;                                                       // cycle 2
    n_checks++;
    if ({mem_en, req_rdy} !== 3'b000) $display("FAIL read_c2_idle: got en=%b rdy=%b want 0 00", mem_en, req_rdy);
    else n_pass++;
    cyc(); mem_rdata = 8'hA7; #1;                                    // cycle 3
    n_checks++;
    if ({req_rdy, req_rdata} !== {2'b01, 16'h00A7})
      $display("FAIL read_cpl: got rdy=%b data=%0h want rdy=01 data=00a7", req_rdy, req_rdata);
    else n_pass++;
    cyc(); clear_inputs(); #1;                                       // cooldown
    n_checks++;
    if ({req_rdy, req_rdata} !== 18'h0) $display("FAIL read_pulse_len: got rdy=%b data=%0h want 0", req_rdy, req_rdata);
    else n_pass++;
  endtask

  task automatic test_masked_write();
    cyc(); set_lane(1, 1'b0, 1'b1, 9'h1F0, 8'hFF, 4'd4);            // cycle 0
    cyc(); #1;                                                       // cycle 1
    n_checks++;
    if ({mem_en, mem_we, mem_addr, mem_mask, mem_wdata} !== {1'b1, 1'b1, 9'h1F0, 8'h0F, 8'h0F})
      $display("FAIL write_access: got en=%b we=%b addr=%0h mask=%0h wdata=%0h want 1 1 1f0 0f 0f",
               mem_en, mem_we, mem_addr, mem_mask, mem_wdata);
    else n_pass++;
    cyc(); #1;                                                       // cycle 2
    n_checks++;
    if ({req_rdy, req_rdata, mem_en} !== {2'b10, 16'h0000, 1'b0})
      $display("FAIL write_cpl: got rdy=%b data=%0h en=%b want 10 0 0", req_rdy, req_rdata, mem_en);
    else n_pass++;
    cyc(); clear_inputs(); #1;                                       // cooldown
    n_checks++;
    if (req_rdy !== 2'b00) $display("FAIL write_pulse_len: got %b want 00", req_rdy); else n_pass++;
  endtask

  task automatic test_size_edges();
    cyc(); set_lane(0, 1'b1, 1'b0, 9'h0AA, 8'h00, 4'd0);            // size 0 read
    cyc(); #1;
    n_checks++;
    if ({mem_en, mem_mask} !== {1'b1, 8'h00}) $display("FAIL size0_mask: got en=%b mask=%0h want 1 00", mem_en, mem_mask);
    else n_pass++;
    cyc(); cyc(); mem_rdata = 8'hFF; #1;
    n_checks++;
    if ({req_rdy, req_rdata} !== {2'b01, 16'h0000})
      $display("FAIL size0_cpl: got rdy=%b data=%0h want 01 0000", req_rdy, req_rdata);
    else n_pass++;
    cyc(); clear_inputs();
    cyc(); set_lane(1, 1'b0, 1'b1, 9'h101, 8'hA5, 4'd15);           // size 15 write
    cyc(); #1;
    n_checks++;
    if ({mem_mask, mem_wdata} !== {8'hFF, 8'hA5})
      $display("FAIL size15_mask: got mask=%0h wdata=%0h want ff a5", mem_mask, mem_wdata);
    else n_pass++;
    cyc(); #1;
    n_checks++;
    if (req_rdy !== 2'b10) $display("FAIL size15_cpl: got %b want 10", req_rdy); else n_pass++;
    cyc(); clear_inputs();
  endtask

  // Both lanes read continuously from reset: mem_en at cycles 1,6,11,16 (lanes 0,1,0,1),
  // completions at 3,8,13,18.
  task automatic test_contention();
    logic       exp_en;
    logic [1:0] exp_rdy;
    int         j;
    cyc(); reset = 1'b0;
    cyc(); reset = 1'b1;
    cyc();
    set_lane(0, 1'b1, 1'b0, 9'h011, 8'h00, 4'd8);
    set_lane(1, 1'b1, 1'b0, 9'h122, 8'h00, 4'd3);
    mem_rdata = 8'h5A;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) cyc();
      #1;
      exp_en  = (k % 5 == 1);
      exp_rdy = 2'b00;
      if (k % 5 == 3) begin
        j = (k - 3) / 5;
        exp_rdy = (j % 2 == 0) ? 2'b01 : 2'b10;
      end
      n_checks++;
      if ({mem_en, req_rdy} !== {exp_en, exp_rdy})
        $display("FAIL contention_c%0d: got en=%b rdy=%b want en=%b rdy=%b", k, mem_en, req_rdy, exp_en, exp_rdy);
      else n_pass++;
      if (exp_en) begin
        j = (k - 1) / 5;
        n_checks++;
        if (mem_addr !== ((j % 2 == 0) ? 9'h011 : 9'h122))
          $display("FAIL contention_addr_c%0d: got %0h want %0h", k, mem_addr, (j % 2 == 0) ? 9'h011 : 9'h122);
        else n_pass++;
      end
      if (exp_rdy != 2'b00) begin
        n_checks++;
        if (req_rdata !== ((exp_rdy == 2'b01) ? 16'h005A : 16'h0200))
          $display("FAIL contention_data_c%0d: got %0h want %0h", k, req_rdata,
                   (exp_rdy == 2'b01) ? 16'h005A : 16'h0200);
        else n_pass++;
      end
    end
    cyc(); clear_inputs();
    cyc(); cyc(); cyc();
  endtask

  task automatic test_protocol();
    cyc(); set_lane(0, 1'b1, 1'b1, 9'h077, 8'h00, 4'd8); #1;        // cycle 0
    n_checks++;
    if (err !== 1'b0) $display("FAIL proto_err_before: got %b want 0", err); else n_pass++;
    cyc(); #1;                                                       // cycle 1
    n_checks++;
    if ({mem_en, mem_we, err} !== {1'b1, 1'b0, EXP_ERR})
      $display("FAIL proto_c1: got en=%b we=%b err=%b want 1 0 %b", mem_en, mem_we, err, EXP_ERR);
    else n_pass++;
    cyc(); cyc(); mem_rdata = 8'h3E; #1;                             // cycle 3
    n_checks++;
    if ({req_rdy, req_rdata} !== {2'b01, 16'h003E})
      $display("FAIL proto_cpl: got rdy=%b data=%0h want 01 003e", req_rdy, req_rdata);
    else n_pass++;
    cyc(); clear_inputs();
    cyc(); cyc(); #1;
    n_checks++;
    if (err !== EXP_ERR) $display("FAIL proto_err_sticky: got %b want %b", err, EXP_ERR); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_single_read();
    test_masked_write();
    test_size_edges();
    test_contention();
    test_protocol();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

Two-lane memory arbiter between a Bambu-generated accelerator's dual master memory port (`Mout_*` lanes 0 and 1) and one single-port external memory with fixed access latency. Per-lane level requests are serialized onto the shared port using round-robin priority. The arbiter generates a per-lane `DataRdy`-style completion pulse with read data. It sits between the HLS core and the off-chip/BRAM model in both synthesis wrappers and simulation benches.

## Interface

**Parameters**
- `ADDR_W`, 9: address width per lane.
- `DATA_W`, 8: data width per lane.
- `SIZE_W`, 4: access-size field width per lane, in bits-count encoding.
- `RD_LAT`, 2: memory read latency in cycles, ≥1.
- `WR_LAT`, 1: memory write completion latency in cycles, ≥1.

**Ports**

Clock and reset (already decided): one clock, `clock`; reset `reset` is asynchronous, active-low.

- `clock`  in  1  system clock, all logic on the rising edge.
- `reset`  in  1  asynchronous active-low reset.
- `req_oe`  in  2  per-lane read request (level).
- `req_we`  in  2  per-lane write request (level).
- `req_addr`  in  2*ADDR_W  lane i at `[i*ADDR_W +: ADDR_W]`.
- `req_wdata`  in  2*DATA_W  per-lane write data.
- `req_size`  in  2*SIZE_W  per-lane access size (number of valid bits).
- `req_rdata`  out  2*DATA_W  per-lane read data, valid only while that lane's `req_rdy` is high, else 0.
- `req_rdy`  out  2  per-lane one-cycle completion pulse.
- `mem_en`  out  1  memory access strobe, one cycle per transaction.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  access address.
- `mem_wdata`  out  DATA_W  write data, already ANDed with `mem_mask`.
- `mem_mask`  out  DATA_W  bit-enable mask.
- `mem_rdata`  in  DATA_W  read data; valid exactly `RD_LAT` cycles after the `mem_en` cycle.
- `err`  out  1  sticky protocol-error flag.

## Operation

**States**
- IDLE:
  - No request: stay in IDLE.
  - Any request present: choose the winner, latch channel, type, address, masked data and mask, then go to ACCESS.
  - Request on lane i means `req_oe[i] | req_we[i]`.
- ACCESS:
  - Lasts one cycle; `mem_en=1` and the latched fields drive the `mem_*` outputs.
  - Load counter `cnt` with `RD_LAT` (read) or `WR_LAT` (write), then go to WAIT.
- WAIT:
  - Decrement `cnt` each cycle.
  - In the cycle `cnt==1`, `req_rdy[win]=1`.
  - For a read, `req_rdata` lane `win` = `mem_rdata & mask`.
  - Then go to COOLDOWN.
- COOLDOWN:
  - Lasts one cycle; requests are ignored while the requester drops its stale request.
  - Round-robin pointer ← `~win`. Go to IDLE.

**Arbitration**
- If only one lane requests, that lane wins.
- If both lanes request, lane `ptr` wins.
- `ptr` resets to 0.

**Mask**
- `mask = (1<<size)-1` truncated to `DATA_W`.
- `size ≥ DATA_W` → all ones.
- `size == 0` → mask 0; the access still occurs and still completes.

**Request and output rules**
- Requests must hold `oe`/`we`/`addr`/`wdata`/`size` stable until their `req_rdy`. Only the IDLE-cycle sample is used.
- When not in ACCESS, `mem_*` outputs are 0.

## Timing

**Reset values**
- While `reset=0`, every output is 0, state = IDLE, `ptr` = 0, `cnt` = 0.
- Reset asserted mid-transaction aborts it: no `req_rdy` is issued, and no `mem_en` is issued after reset.

**Request-to-completion timing** (request first seen in IDLE during cycle 0)
- `mem_en` is high in cycle 1.
- Read: `req_rdy` is high in cycle 1+`RD_LAT` (default cycle 3).
- Write: `req_rdy` is high in cycle 1+`WR_LAT` (default cycle 2).
- COOLDOWN occupies the next cycle; IDLE follows.

**Throughput and pulses**
- Back-to-back spacing is `LAT`+3 cycles per transaction.
- `req_rdy` is never high on both lanes at once and is never longer than one cycle.

**Simultaneous events**
- Both lanes requesting in IDLE: the `ptr` lane is served; the other lane is served at the next IDLE, provided it still requests.
- A new request arriving during ACCESS/WAIT/COOLDOWN waits for IDLE.

**Counter**
- `cnt` width = `clog2(max(RD_LAT,WR_LAT))+1`.

## Configuration

`MEM_ARB_PROTOCOL_CHECK_EN`

**Defined** — `err` is set, and held until reset, if any of these occur:
- `req_oe[i] & req_we[i]` in any cycle.
- A granted lane drops its request before its `req_rdy`.
- The granted lane's `req_addr` changes before its `req_rdy`.

If the first case (both strobes) is seen in IDLE, that lane is treated as a read.

**Undefined** — checking logic is absent and `err` is tied to 0; functional behaviour is otherwise identical.

## Test plan

- **Reset values:** reset low mid-WAIT of a read → all outputs 0 immediately. Release reset → no `req_rdy`; first `mem_en` only on a new request.
- **Single read:** lane 0 reads addr 0x05, size 8, memory returns 0xA7 → `mem_en` in cycle 1, `req_rdy=2'b01` in cycle 3, `req_rdata=16'h00A7`.
- **Masked write:** lane 1 writes 0xFF, size 4, addr 0x1F0 → `mem_we=1`, `mem_mask=0x0F`, `mem_wdata=0x0F`, `mem_addr=0x1F0`; `req_rdy=2'b10` in cycle 2.
- **Contention:** both lanes read continuously from reset → grants alternate 0,1,0,1, with `mem_en` pulses 5 cycles apart.
- **Size edge cases:** size 0 → mask 0x00 and `req_rdy` still pulses. Size 15 → mask 0xFF.
- **Protocol check:** with `MEM_ARB_PROTOCOL_CHECK_EN`, lane 0 drives `oe=we=1` → `err` rises next cycle and stays high; without the macro, `err` stays 0.
